// File: rtl/lzc_norm_pkg.sv
// Shared types and helpers for the leading-zero normalization scheduler.
// The result struct carries exponent/id at their widest supported widths; users narrow them.
package lzc_norm_pkg;

  localparam int MANT_W    = 24;
  localparam int LZ_W      = 5;
  localparam int EXP_MAX_W = 16;
  localparam int ID_MAX_W  = 3;

  typedef struct packed {
    logic [MANT_W-1:0]    mant;
    logic [EXP_MAX_W-1:0] exp;
    logic [LZ_W-1:0]      lz;
    logic [ID_MAX_W-1:0]  id;
    logic                 zero;
    logic                 uflow;
  } norm_res_t;

  // Scans upward so the highest set bit is the last one to write the count.
  function automatic logic [LZ_W-1:0] lz24(input logic [MANT_W-1:0] mant);
    logic [LZ_W-1:0] cnt;
    cnt = LZ_W'(MANT_W);
    for (int i = 0; i < MANT_W; i++) begin
      if (mant[i]) cnt = LZ_W'(MANT_W - 1 - i);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/lzc_rr_arb.sv
// Combinational round-robin arbiter: searches req from ptr upward with wrap,
// and proposes the pointer just past the winner when advance is asserted.
module lzc_rr_arb #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          advance,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] ptr_next
);

  logic          found;
  logic [PW-1:0] win_next;

  always_comb begin
    gnt      = '0;
    found    = 1'b0;
    win_next = ptr;
    // First pass covers ptr..N-1, second pass the wrapped range 0..ptr-1.
    for (int i = 0; i < N; i++) begin
      if (!found && req[i] && (i >= int'(ptr))) begin
        found    = 1'b1;
        gnt[i]   = 1'b1;
        win_next = (i == N - 1) ? '0 : PW'(i + 1);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && req[i] && (i < int'(ptr))) begin
        found    = 1'b1;
        gnt[i]   = 1'b1;
        win_next = (i == N - 1) ? '0 : PW'(i + 1);
      end
    end
    ptr_next = (advance && found) ? win_next : ptr;
  end

endmodule

// File: rtl/lzc_norm_sched.sv
// Shared 24-bit normalization engine behind a round-robin arbiter, two-stage valid/ready pipe.
// Optional per-requester accept counters: define LZC_NORM_SCHED_STATS_EN.
module lzc_norm_sched
  import lzc_norm_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int EXP_W   = 8,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*24-1:0]    req_mant,
  input  logic [NUM_REQ*EXP_W-1:0] req_exp,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [23:0]              out_mant,
  output logic [EXP_W-1:0]         out_exp,
  output logic [4:0]               out_lz,
  output logic [ID_W-1:0]          out_id,
  output logic                     out_zero,
  output logic                     out_uflow
`ifdef LZC_NORM_SCHED_STATS_EN
  ,
  input  logic [ID_W-1:0]          stat_sel,
  output logic [15:0]              stat_cnt
`endif
);

  // EXP_W is expected in LZ_W..EXP_MAX_W so lz fits the exponent and the struct.
  logic [MANT_W-1:0] mant_arr [NUM_REQ];
  logic [EXP_W-1:0]  exp_arr  [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign mant_arr[gi] = req_mant[MANT_W*gi +: MANT_W];
    assign exp_arr[gi]  = req_exp[EXP_W*gi +: EXP_W];
  end

  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [NUM_REQ-1:0] gnt;
  logic               a_valid_q;
  logic [MANT_W-1:0]  a_mant_q;
  logic [EXP_W-1:0]   a_exp_q;
  logic [ID_W-1:0]    a_id_q;
  logic               out_valid_q;
  norm_res_t          res_q, res_d;
  logic               b_ready, a_ready, accept, a_fire;

  assign b_ready   = !out_valid_q || out_ready;
  assign a_ready   = !a_valid_q || b_ready;
  assign req_ready = gnt & {NUM_REQ{a_ready}};
  assign accept    = a_ready && (|gnt);
  assign a_fire    = a_valid_q && b_ready;

  lzc_rr_arb #(
    .N  (NUM_REQ),
    .PW (ID_W)
  ) u_arb (
    .req      (req_valid),
    .ptr      (ptr_q),
    .advance  (accept),
    .gnt      (gnt),
    .ptr_next (ptr_d)
  );

  logic [MANT_W-1:0] sel_mant;
  logic [EXP_W-1:0]  sel_exp;
  logic [ID_W-1:0]   sel_id;

  always_comb begin
    sel_mant = '0;
    sel_exp  = '0;
    sel_id   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_mant = mant_arr[i];
        sel_exp  = exp_arr[i];
        sel_id   = ID_W'(i);
      end
    end
  end

  logic [LZ_W-1:0]  lz;
  logic [EXP_W-1:0] lz_ext;

  // An lz larger than the exponent stops at exp, leaving a denormal result.
  always_comb begin
    lz       = lz24(a_mant_q);
    lz_ext   = EXP_W'(lz);
    res_d    = '0;
    res_d.id = ID_MAX_W'(a_id_q);
    if (lz == LZ_W'(MANT_W)) begin
      res_d.zero = 1'b1;
      res_d.lz   = lz;
    end else if (lz_ext <= a_exp_q) begin
      res_d.mant = a_mant_q << lz;
      res_d.exp  = EXP_MAX_W'(a_exp_q - lz_ext);
      res_d.lz   = lz;
    end else begin
      res_d.uflow = 1'b1;
      res_d.mant  = a_mant_q << a_exp_q;
      res_d.lz    = a_exp_q[LZ_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      a_valid_q   <= 1'b0;
      a_mant_q    <= '0;
      a_exp_q     <= '0;
      a_id_q      <= '0;
      out_valid_q <= 1'b0;
      res_q       <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (accept) begin
        a_valid_q <= 1'b1;
        a_mant_q  <= sel_mant;
        a_exp_q   <= sel_exp;
        a_id_q    <= sel_id;
      end else if (a_fire) begin
        a_valid_q <= 1'b0;
      end
      if (a_fire) begin
        out_valid_q <= 1'b1;
        res_q       <= res_d;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_mant  = res_q.mant;
  assign out_exp   = EXP_W'(res_q.exp);
  assign out_lz    = res_q.lz;
  assign out_id    = ID_W'(res_q.id);
  assign out_zero  = res_q.zero;
  assign out_uflow = res_q.uflow;

`ifdef LZC_NORM_SCHED_STATS_EN
  logic [15:0] cnt_q [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stat
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q[gi] <= '0;
      end else if (req_valid[gi] && req_ready[gi] && (cnt_q[gi] != 16'hFFFF)) begin
        cnt_q[gi] <= cnt_q[gi] + 16'd1;
      end
    end
  end

  assign stat_cnt = (int'(stat_sel) < NUM_REQ) ? cnt_q[stat_sel] : 16'h0000;
`endif

endmodule

// File: tb/tb_lzc_norm_sched.sv
// Directed bench for lzc_norm_sched: normalization cases, round-robin order,
// backpressure, async reset; stats counters when LZC_NORM_SCHED_STATS_EN is defined.
module tb_lzc_norm_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [95:0] req_mant;
  logic [31:0] req_exp;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_mant;
  logic [7:0]  out_exp;
  logic [4:0]  out_lz;
  logic [1:0]  out_id;
  logic        out_zero;
  logic        out_uflow;
`ifdef LZC_NORM_SCHED_STATS_EN
  logic [1:0]  stat_sel;
  logic [15:0] stat_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  // Per-requester operands for the multi-requester tests and their normalized results.
  logic [23:0] op_mant [4] = '{24'h000001, 24'h0F0000, 24'h400000, 24'h000300};
  logic [7:0]  op_exp  [4] = '{8'd30, 8'd10, 8'd1, 8'd20};
  logic [23:0] ex_mant [4] = '{24'h800000, 24'hF00000, 24'h800000, 24'hC00000};
  logic [7:0]  ex_exp  [4] = '{8'd7, 8'd6, 8'd0, 8'd6};

  always #5 clk = ~clk;

  lzc_norm_sched #(
    .NUM_REQ (4),
    .EXP_W   (8),
    .ID_W    (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_mant  (req_mant),
    .req_exp   (req_exp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mant  (out_mant),
    .out_exp   (out_exp),
    .out_lz    (out_lz),
    .out_id    (out_id),
    .out_zero  (out_zero),
    .out_uflow (out_uflow)
`ifdef LZC_NORM_SCHED_STATS_EN
    ,
    .stat_sel  (stat_sel),
    .stat_cnt  (stat_cnt)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) begin
      n_pass++;
      $display("check %s: %0h", tag, got);
    end else begin
      $display("FAIL %s: got %0h, want %0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [23:0] m, input logic [7:0] e);
    req_mant[24*i +: 24] = m;
    req_exp[8*i +: 8]    = e;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic check_res(input string tag, input logic [23:0] m, input logic [7:0] e,
                           input logic [4:0] lz, input logic [1:0] id, input logic z,
                           input logic u);
    check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
    check_eq({tag, "_mant"},  32'(out_mant),  32'(m));
    check_eq({tag, "_exp"},   32'(out_exp),   32'(e));
    check_eq({tag, "_lz"},    32'(out_lz),    32'(lz));
    check_eq({tag, "_id"},    32'(out_id),    32'(id));
    check_eq({tag, "_zero"},  32'(out_zero),  32'(z));
    check_eq({tag, "_uflow"}, 32'(out_uflow), 32'(u));
  endtask

  // One isolated operand on requester id; leaves the result presented at cycle N+2.
  task automatic run_one(input string tag, input int id, input logic [23:0] m,
                         input logic [7:0] e);
    set_req(id, m, e);
    req_valid = 4'(1 << id);
    #1;
    check_eq({tag, "_rdy"}, 32'(req_ready), 32'(1 << id));
    tick();
    req_valid = '0;
    check_eq({tag, "_lat1"}, 32'(out_valid), 32'd0);
    tick();
  endtask

  initial begin
    int acc;
    rst_n     = 1'b0;
    req_valid = '0;
    req_mant  = '0;
    req_exp   = '0;
    out_ready = 1'b1;
`ifdef LZC_NORM_SCHED_STATS_EN
    stat_sel  = 2'd2;
`endif
    #12;
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_mant",  32'(out_mant),  32'd0);
    check_eq("rst_exp",   32'(out_exp),   32'd0);
    check_eq("rst_lz",    32'(out_lz),    32'd0);
    check_eq("rst_id",    32'(out_id),    32'd0);
    check_eq("rst_zero",  32'(out_zero),  32'd0);
    check_eq("rst_uflow", 32'(out_uflow), 32'd0);
    check_eq("rst_rdy",   32'(req_ready), 32'd0);
    #1;
    rst_n = 1'b1;
    tick();

    run_one("basic", 1, 24'h001234, 8'd20);
    check_res("basic", 24'h91A000, 8'd9, 5'd11, 2'd1, 1'b0, 1'b0);
    run_one("zero", 0, 24'h000000, 8'd50);
    check_res("zero", 24'h000000, 8'd0, 5'd24, 2'd0, 1'b1, 1'b0);
    run_one("uflow", 3, 24'h000100, 8'd3);
    check_res("uflow", 24'h000800, 8'd0, 5'd3, 2'd3, 1'b0, 1'b1);
    run_one("lz_eq_exp", 2, 24'h000100, 8'd15);
    check_res("lz_eq_exp", 24'h800000, 8'd0, 5'd15, 2'd2, 1'b0, 1'b0);
    run_one("lz0", 0, 24'h800001, 8'd0);
    check_res("lz0", 24'h800001, 8'd0, 5'd0, 2'd0, 1'b0, 1'b0);
    tick();

    // Round-robin order from reset with all requesters held valid.
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, op_mant[i], op_exp[i]);
    req_valid = 4'hF;
    out_ready = 1'b1;
    #1;
    for (int k = 0; k < 8; k++) begin
      check_eq($sformatf("rr_gnt%0d", k), 32'(req_ready), 32'(1 << (k % 4)));
      tick();
      if (k >= 1) begin
        check_eq($sformatf("rr_id%0d", k), 32'(out_id), 32'((k - 1) % 4));
        check_eq($sformatf("rr_mant%0d", k), 32'(out_mant), 32'(ex_mant[(k - 1) % 4]));
      end
    end
    req_valid = '0;
    tick();
    tick();

    // Backpressure: both stages fill, then the arbiter must stop granting.
    do_reset();
    out_ready = 1'b0;
    req_valid = 4'hF;
    acc = 0;
    #1;
    for (int k = 0; k < 5; k++) begin
      acc += $countones(req_valid & req_ready);
      tick();
    end
    check_eq("bp_accepts", 32'(acc), 32'd2);
    check_eq("bp_rdy", 32'(req_ready), 32'd0);
    check_eq("bp_id", 32'(out_id), 32'd0);
    check_eq("bp_mant", 32'(out_mant), 32'(ex_mant[0]));
    check_eq("bp_exp", 32'(out_exp), 32'(ex_exp[0]));
    out_ready = 1'b1;
    req_valid = '0;
    tick();
    check_eq("drain1_valid", 32'(out_valid), 32'd1);
    check_eq("drain1_id", 32'(out_id), 32'd1);
    check_eq("drain1_mant", 32'(out_mant), 32'(ex_mant[1]));
    check_eq("drain1_exp", 32'(out_exp), 32'(ex_exp[1]));
    tick();
    check_eq("drain_empty", 32'(out_valid), 32'd0);

    // Async reset with both stages full; pointer must return to requester 0.
    do_reset();
    out_ready = 1'b0;
    req_valid = 4'hF;
    tick();
    tick();
    check_eq("full_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("arst_valid", 32'(out_valid), 32'd0);
    check_eq("arst_mant", 32'(out_mant), 32'd0);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    check_eq("arst_gnt", 32'(req_ready), 32'd1);
    tick();
    req_valid = '0;
    tick();
    check_eq("arst_first_id", 32'(out_id), 32'd0);
    check_eq("arst_first_mant", 32'(out_mant), 32'(ex_mant[0]));
    tick();

`ifdef LZC_NORM_SCHED_STATS_EN
    do_reset();
    stat_sel = 2'd2;
    #1;
    check_eq("stat_rst", 32'(stat_cnt), 32'd0);
    req_valid = 4'b0100;
    repeat (100) tick();
    check_eq("stat_100", 32'(stat_cnt), 32'd100);
    repeat (69900) tick();
    check_eq("stat_sat", 32'(stat_cnt), 32'hFFFF);
    req_valid = '0;
    stat_sel = 2'd0;
    #1;
    check_eq("stat_other", 32'(stat_cnt), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
